// File: rtl/mem_port_arbiter_pkg.sv
// ============================================================================
// mem_port_arbiter_pkg : shared state encoding, byte-enable constants, defaults
// Revision: 1.0
// ============================================================================
`default_nettype none

package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_STORE = 2'd2
    } state_t;

    localparam logic [3:0] BE_WORD  = 4'b1111;
    localparam logic [3:0] BE_BYTE0 = 4'b0001;

    localparam int DEFAULT_TAG_W   = 6;
    localparam int DEFAULT_TIMEOUT = 255;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
// ============================================================================
// mem_port_arbiter_if : load/store requester and memory-side bus bundle
// Revision: 1.0
// ============================================================================
`default_nettype none

interface mem_port_arbiter_if #(
    parameter int TAG_W = 6
);
    logic             ld_valid;
    logic [31:0]      ld_addr;
    logic             ld_byte;
    logic [TAG_W-1:0] ld_tag;
    logic             ld_ready;

    logic             st_valid;
    logic [31:0]      st_addr;
    logic [31:0]      st_data;
    logic             st_byte;
    logic             st_ready;

    logic             ld_done;
    logic [31:0]      ld_data;
    logic [TAG_W-1:0] ld_tag_out;

    logic             mem_req;
    logic             mem_we;
    logic [31:0]      mem_addr;
    logic [31:0]      mem_wdata;
    logic [3:0]       mem_be;
    logic             mem_ack;
    logic [31:0]      mem_rdata;

    // Arbiter side
    modport slave (
        input  ld_valid, ld_addr, ld_byte, ld_tag,
        input  st_valid, st_addr, st_data, st_byte,
        input  mem_ack, mem_rdata,
        output ld_ready, st_ready, ld_done, ld_data, ld_tag_out,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be
    );

    // Requester plus memory model side
    modport master (
        output ld_valid, ld_addr, ld_byte, ld_tag,
        output st_valid, st_addr, st_data, st_byte,
        output mem_ack, mem_rdata,
        input  ld_ready, st_ready, ld_done, ld_data, ld_tag_out,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be
    );

endinterface

`default_nettype wire

// File: rtl/mem_lane_align.sv
// ============================================================================
// mem_lane_align : byte-enable / write-lane generation and LB extract+sign-ext
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_lane_align
    import mem_port_arbiter_pkg::*;
(
    input  wire logic [1:0]  req_lane,
    input  wire logic        req_byte,
    input  wire logic [31:0] req_data,
    output logic      [3:0]  req_be,
    output logic      [31:0] req_wdata,

    input  wire logic [1:0]  rsp_lane,
    input  wire logic        rsp_byte,
    input  wire logic [31:0] rsp_rdata,
    output logic      [31:0] rsp_data
);

    logic [7:0] rsp_b;

    always_comb begin
        req_be    = req_byte ? (BE_BYTE0 << req_lane) : BE_WORD;
        req_wdata = req_byte ? {4{req_data[7:0]}} : req_data;

        case (rsp_lane)
            2'd0:    rsp_b = rsp_rdata[7:0];
            2'd1:    rsp_b = rsp_rdata[15:8];
            2'd2:    rsp_b = rsp_rdata[23:16];
            default: rsp_b = rsp_rdata[31:24];
        endcase
        rsp_data = rsp_byte ? {{24{rsp_b[7]}}, rsp_b} : rsp_rdata;
    end

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// mem_port_arbiter : round-robin load/store arbiter onto one memory port.
// Optional macro MEM_TIMEOUT_EN adds an ack wait counter and sticky mem_err.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int TAG_W   = DEFAULT_TAG_W,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  wire logic         clk,
    input  wire logic         rst,
    mem_port_arbiter_if.slave bus
`ifdef MEM_TIMEOUT_EN
    ,
    output logic              mem_err
`endif
);

    state_t           state_q, state_d;
    logic             last_ld_q, last_ld_d;
    logic             mem_req_q, mem_req_d;
    logic             mem_we_q, mem_we_d;
    logic [31:0]      mem_addr_q, mem_addr_d;
    logic [31:0]      mem_wdata_q, mem_wdata_d;
    logic [3:0]       mem_be_q, mem_be_d;
    logic [1:0]       lane_q, lane_d;
    logic             byte_q, byte_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             ld_done_q, ld_done_d;
    logic [31:0]      ld_data_q, ld_data_d;
    logic [TAG_W-1:0] ld_tag_out_q, ld_tag_out_d;

    logic             grant_ld, grant_st;
    logic             timed_out;
    logic             end_access;
    logic [1:0]       req_lane;
    logic             req_byte;
    logic [3:0]       req_be;
    logic [31:0]      req_wdata;
    logic [31:0]      rsp_data;

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             err_q, err_d;

    assign timed_out = (wait_cnt_q == CNT_W'(TIMEOUT - 1));
    assign mem_err   = err_q;
`else
    assign timed_out = 1'b0;
`endif

    // With both requesters valid, the one not granted last wins
    assign grant_ld = bus.ld_valid & (~bus.st_valid | ~last_ld_q);
    assign grant_st = bus.st_valid & (~bus.ld_valid |  last_ld_q);

    assign bus.ld_ready = ~rst & (state_q == ST_IDLE) & grant_ld;
    assign bus.st_ready = ~rst & (state_q == ST_IDLE) & grant_st;

    assign req_lane = grant_ld ? bus.ld_addr[1:0] : bus.st_addr[1:0];
    assign req_byte = grant_ld ? bus.ld_byte      : bus.st_byte;

    mem_lane_align u_lane_align (
        .req_lane  (req_lane),
        .req_byte  (req_byte),
        .req_data  (bus.st_data),
        .req_be    (req_be),
        .req_wdata (req_wdata),
        .rsp_lane  (lane_q),
        .rsp_byte  (byte_q),
        .rsp_rdata (bus.mem_rdata),
        .rsp_data  (rsp_data)
    );

    assign end_access = bus.mem_ack | timed_out;

    always_comb begin
        state_d      = state_q;
        last_ld_d    = last_ld_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_be_d     = mem_be_q;
        lane_d       = lane_q;
        byte_d       = byte_q;
        tag_d        = tag_q;
        ld_done_d    = 1'b0;
        ld_data_d    = ld_data_q;
        ld_tag_out_d = ld_tag_out_q;
`ifdef MEM_TIMEOUT_EN
        wait_cnt_d   = wait_cnt_q;
        err_d        = err_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (bus.ld_ready || bus.st_ready) begin
                    state_d    = bus.ld_ready ? ST_LOAD : ST_STORE;
                    last_ld_d  = bus.ld_ready;
                    mem_req_d  = 1'b1;
                    mem_we_d   = bus.st_ready;
                    mem_addr_d = word_align(bus.ld_ready ? bus.ld_addr : bus.st_addr);
                    mem_be_d   = req_be;
                    mem_wdata_d = bus.st_ready ? req_wdata : 32'd0;
                    lane_d     = req_lane;
                    byte_d     = req_byte;
                    tag_d      = bus.ld_ready ? bus.ld_tag : tag_q;
`ifdef MEM_TIMEOUT_EN
                    wait_cnt_d = '0;
`endif
                end
            end

            ST_LOAD, ST_STORE: begin
                if (end_access) begin
                    state_d   = ST_IDLE;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    // A timed-out load still completes, returning zero data
                    if (state_q == ST_LOAD) begin
                        ld_done_d    = 1'b1;
                        ld_data_d    = bus.mem_ack ? rsp_data : 32'd0;
                        ld_tag_out_d = tag_q;
                    end
                end
`ifdef MEM_TIMEOUT_EN
                if (timed_out && !bus.mem_ack) begin
                    err_d = 1'b1;
                end
                if (!end_access) begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
`endif
            end

            default: begin
                state_d   = ST_IDLE;
                mem_req_d = 1'b0;
                mem_we_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            last_ld_q    <= 1'b1;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= 32'd0;
            mem_wdata_q  <= 32'd0;
            mem_be_q     <= 4'd0;
            lane_q       <= 2'd0;
            byte_q       <= 1'b0;
            tag_q        <= '0;
            ld_done_q    <= 1'b0;
            ld_data_q    <= 32'd0;
            ld_tag_out_q <= '0;
`ifdef MEM_TIMEOUT_EN
            wait_cnt_q   <= '0;
            err_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            last_ld_q    <= last_ld_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_be_q     <= mem_be_d;
            lane_q       <= lane_d;
            byte_q       <= byte_d;
            tag_q        <= tag_d;
            ld_done_q    <= ld_done_d;
            ld_data_q    <= ld_data_d;
            ld_tag_out_q <= ld_tag_out_d;
`ifdef MEM_TIMEOUT_EN
            wait_cnt_q   <= wait_cnt_d;
            err_q        <= err_d;
`endif
        end
    end

    assign bus.mem_req    = mem_req_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.mem_be     = mem_be_q;
    assign bus.ld_done    = ld_done_q;
    assign bus.ld_data    = ld_data_q;
    assign bus.ld_tag_out = ld_tag_out_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// tb_mem_port_arbiter : directed + randomized checks against a behavioural model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

`ifdef MEM_TIMEOUT_EN
    localparam int TMO = 4;
`else
    localparam int TMO = 255;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    mem_port_arbiter_if #(.TAG_W(6)) bus ();

`ifdef MEM_TIMEOUT_EN
    logic mem_err;
`endif

    mem_port_arbiter #(.TAG_W(6), .TIMEOUT(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef MEM_TIMEOUT_EN
        ,
        .mem_err (mem_err)
`endif
    );

    always #5 clk = ~clk;

    int n_run  = 0;
    int n_fail = 0;

    // Reference model state
    bit          next_store;
    logic [31:0] m_ld_data;
    logic [5:0]  m_tag;

    function automatic logic [3:0] exp_be(input logic [31:0] addr, input bit byt);
        return byt ? 4'(1 << (addr % 4)) : 4'hF;
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [31:0] data, input bit byt);
        return byt ? (data & 32'hFF) * 32'h0101_0101 : data;
    endfunction

    function automatic logic [31:0] exp_load(input logic [31:0] addr, input logic [31:0] rdata,
                                             input bit byt);
        logic [31:0] b;
        b = (rdata >> ((addr % 4) * 8)) & 32'hFF;
        if (!byt) return rdata;
        return (b >= 128) ? (b | 32'hFFFF_FF00) : b;
    endfunction

    task automatic idle_inputs();
        bus.ld_valid  = 1'b0; bus.ld_addr = '0; bus.ld_byte = 1'b0; bus.ld_tag = '0;
        bus.st_valid  = 1'b0; bus.st_addr = '0; bus.st_data = '0; bus.st_byte = 1'b0;
        bus.mem_ack   = 1'b0; bus.mem_rdata = '0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        next_store = 1'b1;
        m_ld_data  = '0;
        m_tag      = '0;
        @(negedge clk);
    endtask

    // One access from a single requester; entered and left at a negedge in IDLE
    task automatic do_access(input bit is_ld, input logic [31:0] addr, input logic [31:0] data,
                             input bit byt, input logic [5:0] tag, input int delay,
                             input logic [31:0] rdata, input string name);
        logic [31:0] e_addr, e_wd, e_ld;
        logic [3:0]  e_be;
        e_addr = addr & 32'hFFFF_FFFC;
        e_be   = exp_be(addr, byt);
        e_wd   = exp_wdata(data, byt);
        e_ld   = exp_load(addr, rdata, byt);
        if (is_ld) begin
            bus.ld_valid = 1'b1; bus.ld_addr = addr; bus.ld_byte = byt; bus.ld_tag = tag;
        end else begin
            bus.st_valid = 1'b1; bus.st_addr = addr; bus.st_data = data; bus.st_byte = byt;
        end
        #1;
        n_run++;
        if ({bus.ld_ready, bus.st_ready} !== {is_ld, !is_ld}) begin
            n_fail++;
            $display("FAIL %s ready got ld=%0b st=%0b want ld=%0b", name, bus.ld_ready,
                     bus.st_ready, is_ld);
        end
        @(negedge clk);
        bus.ld_valid = 1'b0; bus.st_valid = 1'b0;
        next_store = is_ld;
        for (int k = 0; k <= delay; k++) begin
            n_run++;
            if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_be, bus.ld_done,
                 bus.ld_ready, bus.st_ready} !== {1'b1, !is_ld, e_addr, e_be, 3'b000}) begin
                n_fail++;
                $display("FAIL %s busy[%0d] got req=%0b we=%0b addr=%h be=%b done=%0b want we=%0b addr=%h be=%b",
                         name, k, bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_be,
                         bus.ld_done, !is_ld, e_addr, e_be);
            end
            if (!is_ld) begin
                n_run++;
                if (bus.mem_wdata !== e_wd) begin
                    n_fail++;
                    $display("FAIL %s wdata got %h want %h", name, bus.mem_wdata, e_wd);
                end
            end
            bus.mem_ack   = (k == delay);
            bus.mem_rdata = (k == delay) ? rdata : $urandom;
            @(negedge clk);
        end
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = $urandom;
        if (is_ld) begin
            m_ld_data = e_ld;
            m_tag     = tag;
        end
        n_run++;
        if ({bus.mem_req, bus.ld_done, bus.ld_data, bus.ld_tag_out} !==
            {1'b0, is_ld, m_ld_data, m_tag}) begin
            n_fail++;
            $display("FAIL %s done got req=%0b done=%0b data=%h tag=%0d want done=%0b data=%h tag=%0d",
                     name, bus.mem_req, bus.ld_done, bus.ld_data, bus.ld_tag_out, is_ld,
                     m_ld_data, m_tag);
        end
        @(negedge clk);
        n_run++;
        if ({bus.ld_done, bus.ld_data, bus.ld_tag_out} !== {1'b0, m_ld_data, m_tag}) begin
            n_fail++;
            $display("FAIL %s hold got done=%0b data=%h tag=%0d want data=%h tag=%0d", name,
                     bus.ld_done, bus.ld_data, bus.ld_tag_out, m_ld_data, m_tag);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        bus.ld_valid = 1'b1; bus.st_valid = 1'b1; bus.mem_ack = 1'b1;
        repeat (2) @(negedge clk);
        n_run++;
        if ({bus.ld_ready, bus.st_ready, bus.ld_done, bus.mem_req, bus.mem_we, bus.mem_be,
             bus.mem_addr, bus.mem_wdata, bus.ld_data, bus.ld_tag_out} !== '0) begin
            n_fail++;
            $display("FAIL reset outputs got rdy=%0b%0b done=%0b req=%0b we=%0b be=%b addr=%h wd=%h ld=%h tag=%0d want all 0",
                     bus.ld_ready, bus.st_ready, bus.ld_done, bus.mem_req, bus.mem_we,
                     bus.mem_be, bus.mem_addr, bus.mem_wdata, bus.ld_data, bus.ld_tag_out);
        end
`ifdef MEM_TIMEOUT_EN
        n_run++;
        if (mem_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset mem_err got %0b want 0", mem_err);
        end
`endif
        apply_reset();
    endtask

    task automatic test_load_word();
        do_access(1'b1, 32'h104, 32'h0, 1'b0, 6'd5, 0, 32'hDEAD_BEEF, "lw_104");
        n_run++;
        if (m_ld_data !== 32'hDEAD_BEEF || bus.ld_data !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL lw_104 ld_data got %h want deadbeef", bus.ld_data);
        end
    endtask

    task automatic test_byte_load();
        do_access(1'b1, 32'h203, 32'h0, 1'b1, 6'd12, 1, 32'h8011_2233, "lb_203");
        n_run++;
        if (bus.ld_data !== 32'hFFFF_FF80) begin
            n_fail++;
            $display("FAIL lb_203 ld_data got %h want ffffff80", bus.ld_data);
        end
    endtask

    task automatic test_byte_store();
        do_access(1'b0, 32'h302, 32'h1234_56A5, 1'b1, 6'd0, 2, 32'h0, "sb_302");
    endtask

    task automatic test_round_robin();
        bit exp_st;
        apply_reset();
        bus.ld_valid = 1'b1; bus.ld_addr = 32'h500; bus.ld_byte = 1'b0; bus.ld_tag = 6'd7;
        bus.st_valid = 1'b1; bus.st_addr = 32'h600; bus.st_data = 32'h55AA_1234;
        bus.st_byte  = 1'b0;
        for (int r = 0; r < 3; r++) begin
            exp_st = next_store;
            #1;
            n_run++;
            if ({bus.st_ready, bus.ld_ready} !== {exp_st, !exp_st}) begin
                n_fail++;
                $display("FAIL rr grant[%0d] got st=%0b ld=%0b want st=%0b", r, bus.st_ready,
                         bus.ld_ready, exp_st);
            end
            @(negedge clk);
            next_store = !exp_st;
            n_run++;
            if ({bus.ld_ready, bus.st_ready, bus.mem_req, bus.mem_we} !== {2'b00, 1'b1, exp_st}) begin
                n_fail++;
                $display("FAIL rr busy[%0d] got rdy=%0b%0b req=%0b we=%0b want rdy=00 req=1 we=%0b",
                         r, bus.ld_ready, bus.st_ready, bus.mem_req, bus.mem_we, exp_st);
            end
            bus.mem_ack = 1'b1; bus.mem_rdata = 32'h0BAD_F00D + r;
            @(negedge clk);
            bus.mem_ack = 1'b0;
            if (!exp_st) begin
                m_ld_data = 32'h0BAD_F00D + r;
                m_tag     = 6'd7;
            end
            n_run++;
            if ({bus.ld_done, bus.ld_data} !== {!exp_st, m_ld_data}) begin
                n_fail++;
                $display("FAIL rr done[%0d] got done=%0b data=%h want done=%0b data=%h", r,
                         bus.ld_done, bus.ld_data, !exp_st, m_ld_data);
            end
        end
        bus.ld_valid = 1'b0; bus.st_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_held_reset();
        apply_reset();
        bus.ld_valid = 1'b1; bus.ld_addr = 32'h40; bus.ld_byte = 1'b0; bus.ld_tag = 6'd3;
        @(negedge clk);
        bus.ld_valid = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            n_run++;
            if ({bus.mem_req, bus.mem_addr} !== {1'b1, 32'h40}) begin
                n_fail++;
                $display("FAIL held cyc%0d got req=%0b addr=%h want req=1 addr=00000040", c,
                         bus.mem_req, bus.mem_addr);
            end
            @(negedge clk);
        end
        #2 rst = 1'b1;
        #1;
        n_run++;
        if ({bus.mem_req, bus.ld_done, bus.ld_ready, bus.st_ready, bus.mem_addr} !== '0) begin
            n_fail++;
            $display("FAIL held_rst got req=%0b done=%0b addr=%h want all 0", bus.mem_req,
                     bus.ld_done, bus.mem_addr);
        end
        @(negedge clk);
        rst = 1'b0;
        next_store = 1'b1; m_ld_data = '0; m_tag = '0;
        for (int c = 6; c <= 10; c++) begin
            n_run++;
            if ({bus.mem_req, bus.ld_done} !== 2'b00) begin
                n_fail++;
                $display("FAIL held_after cyc%0d got req=%0b done=%0b want 0 0", c,
                         bus.mem_req, bus.ld_done);
            end
            @(negedge clk);
        end
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'h1111_2222;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        repeat (2) begin
            n_run++;
            if ({bus.mem_req, bus.ld_done, bus.ld_data} !== {2'b00, 32'h0}) begin
                n_fail++;
                $display("FAIL late_ack got req=%0b done=%0b data=%h want 0 0 0", bus.mem_req,
                         bus.ld_done, bus.ld_data);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_random();
        bit          is_ld, byt;
        logic [31:0] addr, data, rdata;
        logic [5:0]  tag;
        int          dly;
        for (int i = 0; i < 30; i++) begin
            is_ld = $urandom_range(0, 1);
            byt   = $urandom_range(0, 1);
            addr  = $urandom;
            data  = $urandom;
            rdata = $urandom;
            tag   = 6'($urandom_range(0, 63));
            dly   = $urandom_range(0, 3);
            do_access(is_ld, addr, data, byt, tag, dly, rdata, "random");
            if ($urandom_range(0, 3) == 0) begin
                bus.mem_ack = 1'b1; bus.mem_rdata = $urandom;
                @(negedge clk);
                bus.mem_ack = 1'b0;
                n_run++;
                if ({bus.mem_req, bus.ld_done, bus.ld_data} !== {2'b00, m_ld_data}) begin
                    n_fail++;
                    $display("FAIL idle_ack got req=%0b done=%0b data=%h want 0 0 %h",
                             bus.mem_req, bus.ld_done, bus.ld_data, m_ld_data);
                end
            end
        end
    endtask

`ifdef MEM_TIMEOUT_EN
    task automatic test_timeout();
        apply_reset();
        bus.ld_valid = 1'b1; bus.ld_addr = 32'h88; bus.ld_byte = 1'b0; bus.ld_tag = 6'd9;
        @(negedge clk);
        bus.ld_valid = 1'b0;
        for (int c = 0; c < TMO; c++) begin
            n_run++;
            if ({bus.mem_req, mem_err} !== 2'b10) begin
                n_fail++;
                $display("FAIL tmo wait%0d got req=%0b err=%0b want 1 0", c, bus.mem_req, mem_err);
            end
            @(negedge clk);
        end
        n_run++;
        if ({bus.mem_req, mem_err, bus.ld_done, bus.ld_data, bus.ld_tag_out} !==
            {3'b011, 32'h0, 6'd9}) begin
            n_fail++;
            $display("FAIL tmo end got req=%0b err=%0b done=%0b data=%h tag=%0d want 0 1 1 0 9",
                     bus.mem_req, mem_err, bus.ld_done, bus.ld_data, bus.ld_tag_out);
        end
        m_ld_data = 32'h0; m_tag = 6'd9; next_store = 1'b0;
        @(negedge clk);
        do_access(1'b0, 32'h90, 32'h7, 1'b0, 6'd0, 0, 32'h0, "after_tmo");
        n_run++;
        if (mem_err !== 1'b1) begin
            n_fail++;
            $display("FAIL tmo sticky got err=%0b want 1", mem_err);
        end
        apply_reset();
        n_run++;
        if (mem_err !== 1'b0) begin
            n_fail++;
            $display("FAIL tmo clear got err=%0b want 0", mem_err);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_load_word();
        test_byte_load();
        test_byte_store();
        test_round_robin();
        test_held_reset();
        test_random();
`ifdef MEM_TIMEOUT_EN
        test_timeout();
`endif
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter TAG_W, default 6, width of the load destination tag.
REQ-002 SHALL have parameter TIMEOUT, default 255, maximum number of wait cycles for mem_ack.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 ld_valid  input  1  load request present.
REQ-006 ld_addr  input  32  load byte address.
REQ-007 ld_byte  input  1  1 = LB, 0 = LW.
REQ-008 ld_tag  input  TAG_W  load destination tag.
REQ-009 ld_ready  output  1  load request accepted this cycle when ld_valid is also high.
REQ-010 st_valid, st_addr[31:0], st_data[31:0], st_byte  inputs  store request, address, data and size (1 = SB).
REQ-011 st_ready  output  1  store request accepted this cycle when st_valid is also high.
REQ-012 ld_done  output  1  one-cycle pulse: ld_data and ld_tag_out are valid.
REQ-013 ld_data  output  32  load result; ld_tag_out  output  TAG_W  tag of the completed load.
REQ-014 mem_req, mem_we  outputs  1  memory request strobe and write enable.
REQ-015 mem_addr  output  32;  mem_wdata  output  32;  mem_be  output  4  byte enables.
REQ-016 mem_ack  input  1;  mem_rdata  input  32  memory completion and read data.
REQ-017 mem_err  output  1  sticky timeout flag; exists only with MEM_TIMEOUT_EN.

Function
REQ-018 The FSM SHALL have three states: IDLE, LOAD and STORE.
REQ-019 ld_ready and st_ready SHALL be asserted only in IDLE, and at most one of them SHALL be asserted per cycle.
REQ-020 In IDLE with only one of ld_valid or st_valid high, that requester SHALL be granted.
REQ-021 In IDLE with both valid, the grant SHALL be round-robin: the requester not granted last wins; after reset, store wins.
REQ-022 On acceptance (valid & ready), the address, data, size and tag SHALL be registered, and the FSM SHALL enter LOAD or STORE.
REQ-023 In LOAD or STORE, mem_req SHALL be 1 and the mem_* outputs SHALL hold stable until the cycle in which mem_ack is sampled high.
REQ-024 mem_we SHALL be 1 in STORE and 0 in LOAD.
REQ-025 mem_addr SHALL be the registered address with bits [1:0] forced to 0.
REQ-026 mem_be SHALL be 4'b1111 for a word access, and 4'b0001 shifted left by addr[1:0] for a byte access.
REQ-027 For SB, mem_wdata SHALL be st_data[7:0] replicated into all four lanes; for SW, mem_wdata SHALL be st_data.
REQ-028 When mem_ack is sampled in LOAD, the block SHALL in the next cycle pulse ld_done, drive ld_tag_out, and drive ld_data.
REQ-029 ld_data SHALL be mem_rdata for LW, or the byte lane selected by addr[1:0], sign-extended, for LB.
REQ-030 When mem_ack is sampled in LOAD or STORE, the FSM SHALL return to IDLE, so a new grant is possible one cycle after the ack.
REQ-031 Minimum latency SHALL be: accept at cycle N, mem_req at N+1, ack at N+1, ld_done at N+2.
REQ-032 mem_ack in IDLE SHALL be ignored.
REQ-033 ld_data and ld_tag_out SHALL hold their last values when ld_done is 0.

Reset
REQ-034 rst SHALL immediately force: state IDLE; ld_ready, st_ready, ld_done, mem_req, mem_we and mem_err to 0; mem_be, mem_addr, mem_wdata, ld_data and ld_tag_out to 0; round-robin pointer to "store next".
REQ-035 Reset during LOAD or STORE SHALL abandon the access with no ld_done, and any later mem_ack for it SHALL be ignored.

Configuration
REQ-036 With MEM_TIMEOUT_EN defined, a wait counter SHALL clear on entry to LOAD or STORE and increment each cycle without mem_ack.
REQ-037 With MEM_TIMEOUT_EN defined, reaching TIMEOUT SHALL drop mem_req, set mem_err (cleared only by rst), and return the FSM to IDLE.
REQ-038 With MEM_TIMEOUT_EN defined, a load that times out SHALL produce ld_done with ld_data = 0.
REQ-039 Without MEM_TIMEOUT_EN, the block SHALL have no counter and no mem_err port, and SHALL wait for mem_ack indefinitely.

Structure
REQ-040 A shared package SHALL hold the state encoding (IDLE/LOAD/STORE), the byte-enable constants, and the default TIMEOUT.
REQ-041 Byte-lane logic (be/wdata generation, LB extract and sign-extend) SHALL be in one combinational sub-module, mem_lane_align.

Verification
REQ-042 Load accept, then immediate ack: LW at 0x104, rdata 0xDEADBEEF, tag 5 -> mem_be 1111, mem_addr 0x104; ld_done 2 cycles after accept with ld_data 0xDEADBEEF and tag 5.
REQ-043 Byte load with sign extension: LB at 0x203, rdata 0x80112233 -> mem_be 1000, ld_data 0xFFFFFF80.
REQ-044 Byte store lane replication: SB 0xA5 at 0x302 -> mem_we 1, mem_be 0100, mem_wdata 0xA5A5A5A5, no ld_done.
REQ-045 Round-robin after reset: load and store valid together, three times -> grant order store, load, store; ready never high while busy.
REQ-046 Held request then reset: mem_ack held low 10 cycles -> mem_req and mem_addr stable throughout; rst in cycle 5 -> IDLE, no ld_done, a later ack is ignored.
REQ-047 With MEM_TIMEOUT_EN and TIMEOUT 4: load never acked -> mem_req drops after 4 cycles, mem_err 1, ld_done with ld_data 0.
